icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, one-word-per-line instruction cache between the instruction fetch unit and the memory arbiter's instruction port (inst1_*).
- Hits return in the same cycle. A miss issues a single 4-byte read, fills the line, and forwards the word on the fill cycle.
- rob_clear abandons any outstanding miss, in lockstep with the arbiter, which also returns to IDLE on rob_clear.

Parameters:
- INDEX_BITS, 6, log2 of line count (64 lines of 32 bits). TAG_W is derived as 30-INDEX_BITS.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global ready; low freezes all state
- rob_clear  in  1  pipeline flush; cancels any in-flight miss
- inv_all  in  1  one-cycle pulse; invalidates every line
- fetch_valid  in  1  fetch request; fetch_pc is held stable until fetch_ready or rob_clear
- fetch_pc  in  32  word-aligned fetch address (bits 1:0 ignored)
- fetch_ready  out  1  one-cycle pulse; fetch_inst is valid
- fetch_inst  out  32  instruction word
- mem_valid  out  1  read request to the arbiter's inst1 port (registered)
- mem_addr  out  32  read address, registered; equals miss_addr
- mem_result  in  32  returned word
- mem_ready  in  1  one-cycle pulse; mem_result is valid

Behaviour:
- Address split: index = pc[INDEX_BITS+1:2], tag = pc[31:INDEX_BITS+2].
- Storage per line: valid bit, tag, data.
- Reset (rst_in=0, async):
  - all valid bits cleared, state=IDLE, mem_valid=0, mem_addr=0, miss_addr=0.
  - fetch_ready=0, fetch_inst=0. Tag and data arrays need no reset.
- States: IDLE, MISS.
- IDLE:
  - hit = fetch_valid && valid[idx] && tag[idx]==tag(fetch_pc).
  - On hit: fetch_ready=1 and fetch_inst=data[idx], combinationally, in the same cycle.
  - On fetch_valid && !hit: latch miss_addr=fetch_pc, set mem_valid=1, mem_addr=fetch_pc, go to MISS. fetch_ready stays 0.
- MISS:
  - mem_valid stays 1 and mem_addr stays stable until mem_ready.
  - On mem_ready: write valid/tag/data at index(miss_addr), drop mem_valid, return to IDLE.
  - On the same cycle, if fetch_valid && fetch_pc==miss_addr: fetch_ready=1 and fetch_inst=mem_result (bypass).
  - The hit path is disabled while in MISS.
- Minimum miss latency: 1 cycle to issue, plus the arbiter latency, with data forwarded on the mem_ready cycle.
- The first fetch after a fill to the same pc hits the next cycle.
- rob_clear (synchronous, higher priority than everything except reset):
  - next state=IDLE, mem_valid=0.
  - fetch_ready is forced 0 in that cycle.
  - A coincident mem_ready is discarded: no array write, no forward.
  - Cache contents are retained.
- inv_all:
  - clears all valid bits at the clock edge, with priority over a coincident fill (the fill is not recorded).
  - fetch_ready is forced 0 in that cycle. An outstanding miss continues.
- rdy_in=0:
  - no state, array or register update; fetch_ready=0.
  - mem_valid and mem_addr hold their values. A mem_ready seen while rdy_in=0 is ignored.
- fetch_pc changing during MISS without rob_clear is a protocol violation. The fill still targets miss_addr, and no forward is given unless the pc matches.
- fetch_ready is never asserted while fetch_valid=0.
- Index wrap: pc values 0x0000_0000 and 0x0000_0100 (INDEX_BITS=6) alias to line 0, and the later fill evicts the earlier one.

Decomposition:
- Package icache_pkg: INDEX_BITS default, TAG_W derivation, state encoding localparams (IDLE=1'b0, MISS=1'b1), index/tag extract helper functions.
- One sub-module: icache_line_array. It holds the valid bit-vector with async clear plus bulk invalidate, and the tag/data register arrays. It has one combinational read port (index) and one synchronous write port (index, tag, data, we).
- The FSM and handshake logic live in icache_direct.

Test Plan:
- Cold miss: fetch_pc=0x1000.
  - Expect mem_valid=1, mem_addr=0x1000 the next cycle.
  - Drive mem_ready with mem_result=0x00500093 three cycles later; expect fetch_ready=1 and fetch_inst=0x00500093 on that cycle.
  - Re-fetch 0x1000; expect a same-cycle hit with no mem_valid.
- Aliasing: fill 0x0000, then 0x0100, then fetch 0x0000. Expect a miss and mem_addr=0x0000.
- Flush mid-miss: miss on 0x2000, then pulse rob_clear together with mem_ready.
  - Expect fetch_ready=0, mem_valid=0, state IDLE.
  - Re-fetch 0x2000; expect a miss again, since the discarded fill was not written.
- inv_all: fill 0x1000 and 0x1004, pulse inv_all, then fetch 0x1004. Expect a miss.
- rdy_in stall: during MISS hold rdy_in=0 for 4 cycles. Expect mem_valid/mem_addr constant and fetch_ready=0. Complete normally once rdy_in=1.
- Async reset: assert rst_in=0 mid-MISS, between clock edges. Expect mem_valid=0 and fetch_ready=0 immediately, and all lines invalid afterwards.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: geometry default,
// FSM encoding and pc index/tag extraction helpers.
package icache_pkg;

    localparam int DEF_INDEX_BITS = 6;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    function automatic int tag_width(input int index_bits);
        return 30 - index_bits;
    endfunction

    // Index and tag are returned right-aligned in 32 bits; callers cast to their width.
    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int index_bits);
        return (pc >> 2) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int index_bits);
        return pc >> (index_bits + 2);
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Line storage: per-line valid bits (async clear and bulk invalidate) plus tag and
// data register arrays with one combinational read port and one synchronous write port.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int TAG_W      = tag_width(DEF_INDEX_BITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inv,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [31:0]           wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags  [LINES];
    logic [31:0]      words [LINES];

    // Bulk invalidate wins over a same-cycle write, so that fill is never recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (inv) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_idx]  <= wr_tag;
            words[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = words[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache: same-cycle hits, single-word
// miss fill through the arbiter's inst1 port with forwarding on the fill cycle.
module icache_direct
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        inv_all,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        fetch_ready,
    output logic [31:0] fetch_inst,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_result,
    input  logic        mem_ready
);

    localparam int TAG_W = tag_width(INDEX_BITS);

    typedef logic [INDEX_BITS-1:0] idx_t;
    typedef logic [TAG_W-1:0]      tag_t;

    state_t      state, state_next;
    logic [31:0] miss_addr, miss_addr_next;
    logic        mem_valid_next;
    logic [31:0] mem_addr_next;

    idx_t        rd_idx, wr_idx;
    tag_t        fetch_tag, wr_tag, rd_tag;
    logic        rd_valid;
    logic [31:0] rd_data;

    logic        accept, hit, fill, bypass, inv;

    assign rd_idx    = idx_t'(pc_index(fetch_pc, INDEX_BITS));
    assign fetch_tag = tag_t'(pc_tag(fetch_pc, INDEX_BITS));
    assign wr_idx    = idx_t'(pc_index(miss_addr, INDEX_BITS));
    assign wr_tag    = tag_t'(pc_tag(miss_addr, INDEX_BITS));

    // A stalled or flushed cycle commits nothing, including a returning fill.
    assign accept = rdy_in && !rob_clear;
    assign hit    = (state == IDLE) && fetch_valid && rd_valid && (rd_tag == fetch_tag);
    assign fill   = accept && (state == MISS) && mem_ready;
    assign bypass = fill && fetch_valid && (fetch_pc == miss_addr);
    assign inv    = rdy_in && inv_all;

    icache_line_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_lines (
        .clk      (clk_in),
        .rst_n    (rst_in),
        .inv      (inv),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (fill),
        .wr_idx   (wr_idx),
        .wr_tag   (wr_tag),
        .wr_data  (mem_result)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            miss_addr <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
        end else begin
            state     <= state_next;
            miss_addr <= miss_addr_next;
            mem_valid <= mem_valid_next;
            mem_addr  <= mem_addr_next;
        end
    end

    always_comb begin
        state_next     = state;
        miss_addr_next = miss_addr;
        mem_valid_next = mem_valid;
        mem_addr_next  = mem_addr;
        if (rdy_in) begin
            if (rob_clear) begin
                state_next     = IDLE;
                mem_valid_next = 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (fetch_valid && !hit) begin
                            state_next     = MISS;
                            miss_addr_next = fetch_pc;
                            mem_valid_next = 1'b1;
                            mem_addr_next  = fetch_pc;
                        end
                    end
                    MISS: begin
                        if (mem_ready) begin
                            state_next     = IDLE;
                            mem_valid_next = 1'b0;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // Gating on rst_in keeps the response quiet for the whole time reset is held.
    always_comb begin
        fetch_ready = 1'b0;
        fetch_inst  = '0;
        if (rst_in && accept && !inv_all) begin
            if (hit) begin
                fetch_ready = 1'b1;
                fetch_inst  = rd_data;
            end else if (bypass) begin
                fetch_ready = 1'b1;
                fetch_inst  = mem_result;
            end
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: scenario tasks drive fetch/arbiter traffic; a queue holds the
// instruction words each delivered fetch must carry, and a negedge monitor consumes it.
module tb_icache_direct;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rob_clear, inv_all, fetch_valid, mem_ready;
    logic [31:0] fetch_pc, mem_result;
    logic        fetch_ready, mem_valid;
    logic [31:0] fetch_inst, mem_addr;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] exp_q[$];

    icache_direct dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .rob_clear   (rob_clear),
        .inv_all     (inv_all),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .fetch_inst  (fetch_inst),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_result  (mem_result),
        .mem_ready   (mem_ready)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, actual t=%0t required < 100000", $time);
        $fatal(1);
    end

    always @(negedge clk_in) begin : monitor
        logic [31:0] exp_word;
        if (fetch_ready) begin
            n_checks++;
            if (fetch_valid !== 1'b1) begin
                n_fails++;
                $display("FAIL ready_without_valid: fetch_valid=%b required 1", fetch_valid);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_ready: fetch_inst=%h pc=%h, no delivery expected", fetch_inst, fetch_pc);
            end else begin
                exp_word = exp_q.pop_front();
                if (fetch_inst !== exp_word) begin
                    n_fails++;
                    $display("FAIL fetch_inst pc=%h: actual %h required %h", fetch_pc, fetch_inst, exp_word);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    // Issues a miss on pc and answers it with data on the first cycle mem_valid is seen.
    task automatic do_fill(input logic [31:0] pc, input logic [31:0] data, output bit timed_out);
        timed_out   = 1'b1;
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (mem_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
        if (!timed_out) begin
            mem_ready  = 1'b1;
            mem_result = data;
            exp_q.push_back(data);
            cyc();
            mem_ready = 1'b0;
        end
        fetch_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0; inv_all = 1'b0;
        fetch_valid = 1'b0; fetch_pc = '0; mem_ready = 1'b0; mem_result = '0;
        #1;
        n_checks++;
        if (mem_valid !== 1'b0 || mem_addr !== 32'h0) begin
            n_fails++;
            $display("FAIL reset_mem: mem_valid=%b mem_addr=%h required 0/00000000", mem_valid, mem_addr);
        end
        n_checks++;
        if (fetch_ready !== 1'b0 || fetch_inst !== 32'h0) begin
            n_fails++;
            $display("FAIL reset_fetch: fetch_ready=%b fetch_inst=%h required 0/00000000", fetch_ready, fetch_inst);
        end
        cyc();
        cyc();
        rst_in = 1'b1;
    endtask

    task automatic test_cold_miss();
        cyc();
        fetch_valid = 1'b1; fetch_pc = 32'h1000;
        #1;
        n_checks++;
        if (fetch_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL cold_no_hit: fetch_ready=%b required 0", fetch_ready);
        end
        cyc();
        n_checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h1000) begin
            n_fails++;
            $display("FAIL cold_issue: mem_valid=%b mem_addr=%h required 1/00001000", mem_valid, mem_addr);
        end
        cyc(); cyc(); cyc();
        mem_ready = 1'b1; mem_result = 32'h00500093;
        exp_q.push_back(32'h00500093);
        #1;
        n_checks++;
        if (fetch_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL cold_forward: fetch_ready=%b required 1", fetch_ready);
        end
        cyc();
        mem_ready = 1'b0; mem_result = 32'hdeadbeef;
        exp_q.push_back(32'h00500093);
        #1;
        n_checks++;
        if (fetch_ready !== 1'b1 || mem_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL cold_rehit: fetch_ready=%b mem_valid=%b required 1/0", fetch_ready, mem_valid);
        end
        cyc();
        fetch_valid = 1'b0;
        n_checks++;
        if (mem_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL cold_no_reissue: mem_valid=%b required 0", mem_valid);
        end
    endtask

    task automatic test_alias();
        bit to_a, to_b;
        do_fill(32'h0000, 32'haaaa0001, to_a);
        do_fill(32'h0100, 32'hbbbb0002, to_b);
        n_checks++;
        if (to_a || to_b) begin
            n_fails++;
            $display("FAIL alias_fill_timeout: timeouts=%b%b required 00", to_a, to_b);
        end
        fetch_valid = 1'b1; fetch_pc = 32'h0000;
        #1;
        n_checks++;
        if (fetch_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL alias_evicted: fetch_ready=%b required 0", fetch_ready);
        end
        cyc();
        n_checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h0000) begin
            n_fails++;
            $display("FAIL alias_issue: mem_valid=%b mem_addr=%h required 1/00000000", mem_valid, mem_addr);
        end
        mem_ready = 1'b1; mem_result = 32'haaaa0001;
        exp_q.push_back(32'haaaa0001);
        cyc();
        mem_ready = 1'b0;
        exp_q.push_back(32'haaaa0001);
        cyc();
        fetch_valid = 1'b0;
    endtask

    task automatic test_flush();
        fetch_valid = 1'b1; fetch_pc = 32'h2000;
        cyc();
        n_checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h2000) begin
            n_fails++;
            $display("FAIL flush_issue: mem_valid=%b mem_addr=%h required 1/00002000", mem_valid, mem_addr);
        end
        cyc();
        rob_clear = 1'b1; mem_ready = 1'b1; mem_result = 32'h12345678;
        #1;
        n_checks++;
        if (fetch_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL flush_no_forward: fetch_ready=%b required 0", fetch_ready);
        end
        cyc();
        rob_clear = 1'b0; mem_ready = 1'b0;
        #1;
        n_checks++;
        if (mem_valid !== 1'b0 || fetch_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL flush_idle: mem_valid=%b fetch_ready=%b required 0/0", mem_valid, fetch_ready);
        end
        cyc();
        n_checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h2000) begin
            n_fails++;
            $display("FAIL flush_remiss: mem_valid=%b mem_addr=%h required 1/00002000", mem_valid, mem_addr);
        end
        mem_ready = 1'b1; mem_result = 32'h22220003;
        exp_q.push_back(32'h22220003);
        cyc();
        mem_ready = 1'b0; fetch_valid = 1'b0;
    endtask

    task automatic test_inv_all();
        bit to_a, to_b;
        do_fill(32'h1000, 32'h10000001, to_a);
        do_fill(32'h1004, 32'h10040002, to_b);
        n_checks++;
        if (to_a || to_b) begin
            n_fails++;
            $display("FAIL inv_fill_timeout: timeouts=%b%b required 00", to_a, to_b);
        end
        fetch_valid = 1'b1; fetch_pc = 32'h1004;
        exp_q.push_back(32'h10040002);
        cyc();
        fetch_valid = 1'b0; inv_all = 1'b1;
        cyc();
        inv_all = 1'b0; fetch_valid = 1'b1; fetch_pc = 32'h1004;
        #1;
        n_checks++;
        if (fetch_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL inv_miss: fetch_ready=%b required 0", fetch_ready);
        end
        cyc();
        n_checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h1004) begin
            n_fails++;
            $display("FAIL inv_issue: mem_valid=%b mem_addr=%h required 1/00001004", mem_valid, mem_addr);
        end
        // Invalidate coinciding with the fill: no forward and the line stays invalid.
        inv_all = 1'b1; mem_ready = 1'b1; mem_result = 32'h10040002;
        #1;
        n_checks++;
        if (fetch_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL inv_fill_forward: fetch_ready=%b required 0", fetch_ready);
        end
        cyc();
        inv_all = 1'b0; mem_ready = 1'b0;
        #1;
        n_checks++;
        if (fetch_ready !== 1'b0 || mem_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL inv_fill_dropped: fetch_ready=%b mem_valid=%b required 0/0", fetch_ready, mem_valid);
        end
        cyc();
        mem_ready = 1'b1; mem_result = 32'h10040002;
        exp_q.push_back(32'h10040002);
        cyc();
        mem_ready = 1'b0; fetch_valid = 1'b0;
    endtask

    task automatic test_stall();
        fetch_valid = 1'b1; fetch_pc = 32'h3000;
        cyc();
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 2); mem_result = 32'hbad00000 | i;
            #1;
            n_checks++;
            if (mem_valid !== 1'b1 || mem_addr !== 32'h3000) begin
                n_fails++;
                $display("FAIL stall_hold[%0d]: mem_valid=%b mem_addr=%h required 1/00003000", i, mem_valid, mem_addr);
            end
            n_checks++;
            if (fetch_ready !== 1'b0) begin
                n_fails++;
                $display("FAIL stall_ready[%0d]: fetch_ready=%b required 0", i, fetch_ready);
            end
            cyc();
        end
        rdy_in = 1'b1; mem_ready = 1'b1; mem_result = 32'h33330004;
        exp_q.push_back(32'h33330004);
        #1;
        n_checks++;
        if (fetch_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL stall_resume: fetch_ready=%b required 1", fetch_ready);
        end
        cyc();
        mem_ready = 1'b0; fetch_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        fetch_valid = 1'b1; fetch_pc = 32'h1004;
        exp_q.push_back(32'h10040002);
        cyc();
        fetch_pc = 32'h4000;
        cyc();
        n_checks++;
        if (mem_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL areset_pre: mem_valid=%b required 1", mem_valid);
        end
        #2;
        rst_in = 1'b0;
        #1;
        n_checks++;
        if (mem_valid !== 1'b0 || mem_addr !== 32'h0 || fetch_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL areset_now: mem_valid=%b mem_addr=%h fetch_ready=%b required 0/00000000/0",
                     mem_valid, mem_addr, fetch_ready);
        end
        cyc(); cyc();
        rst_in = 1'b1; fetch_pc = 32'h1004;
        #1;
        n_checks++;
        if (fetch_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL areset_invalid: fetch_ready=%b required 0", fetch_ready);
        end
        cyc();
        n_checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h1004) begin
            n_fails++;
            $display("FAIL areset_remiss: mem_valid=%b mem_addr=%h required 1/00001004", mem_valid, mem_addr);
        end
        mem_ready = 1'b1; mem_result = 32'h44440005;
        exp_q.push_back(32'h44440005);
        cyc();
        mem_ready = 1'b0; fetch_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_alias();
        test_flush();
        test_inv_all();
        test_stall();
        test_async_reset();
        cyc(); cyc();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: %0d deliveries outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
